// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared digit width, default modulus and terminal-value helpers
package counter_pkg;

    localparam int DIGIT_W           = 4;
    localparam int DEFAULT_DIGIT_MOD = 10;

    // Terminal value when counting up: the largest legal digit code.
    function automatic logic [DIGIT_W-1:0] term_up(input int mod);
        return DIGIT_W'(mod - 1);
    endfunction

    // Terminal value when counting down.
    function automatic logic [DIGIT_W-1:0] term_dn();
        return '0;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one modulo-N up/down digit with clamped parallel load
module bcd_digit
    import counter_pkg::*;
#(
    parameter int DIGIT_MOD = DEFAULT_DIGIT_MOD
) (
    input  logic               clki,
    input  logic               reset,
    input  logic               step,
    input  logic               up_down,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    output logic [DIGIT_W-1:0] q_digit,
    output logic               at_term
);

    localparam logic [DIGIT_W-1:0] TERM_UP = term_up(DIGIT_MOD);
    localparam logic [DIGIT_W-1:0] TERM_DN = term_dn();
    localparam logic [DIGIT_W:0]   MOD_EXT = (DIGIT_W + 1)'(DIGIT_MOD);

    logic [DIGIT_W-1:0] load_clamped;

    // Out-of-range load codes are pulled down to the top legal code so no illegal digit is ever stored.
    always_comb begin
        load_clamped = load_digit;
        if ({1'b0, load_digit} >= MOD_EXT) begin
            load_clamped = TERM_UP;
        end
    end

    // Terminal is direction dependent; the top cascades on it.
    always_comb begin
        at_term = up_down ? (q_digit == TERM_UP) : (q_digit == TERM_DN);
    end

    // Digit register: load wins over step; step rolls over at either end of the range.
    always_ff @(posedge clki or negedge reset) begin
        if (!reset) begin
            q_digit <= '0;
        end else if (load) begin
            q_digit <= load_clamped;
        end else if (step) begin
            if (up_down) begin
                q_digit <= (q_digit == TERM_UP) ? TERM_DN : q_digit + 1'b1;
            end else begin
                q_digit <= (q_digit == TERM_DN) ? TERM_UP : q_digit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - cascaded multi-digit modulo up/down counter with wrap or saturate
module bcd_updown_counter
    import counter_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int DIGIT_MOD = DEFAULT_DIGIT_MOD,
    parameter int WRAP      = 1
) (
    input  logic                        clki,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        up_down,
    input  logic                        load,
    input  logic [DIGIT_W*DIGITS-1:0]   load_val,
    output logic [DIGIT_W*DIGITS-1:0]   q,
    output logic                        tc,
    output logic                        wrap_pulse,
    output logic                        sat
);

    localparam bit WRAP_EN = (WRAP != 0);

    logic [DIGITS-1:0] at_term;
    logic [DIGITS-1:0] step;
    logic [DIGITS:0]   lower_term;
    logic              count;
    logic              all_term;

    // lower_term[k] is high when every digit below k sits at its terminal value.
    always_comb begin
        lower_term[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            lower_term[k+1] = lower_term[k] & at_term[k];
        end
    end

    // Step enables: in saturate mode nothing moves once the whole value is at terminal.
    always_comb begin
        count    = enable & ~load;
        all_term = lower_term[DIGITS];
        tc       = count & all_term;
        for (int k = 0; k < DIGITS; k++) begin
            step[k] = count & lower_term[k] & (WRAP_EN | ~all_term);
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit #(
            .DIGIT_MOD (DIGIT_MOD)
        ) u_digit (
            .clki       (clki),
            .reset      (reset),
            .step       (step[k]),
            .up_down    (up_down),
            .load       (load),
            .load_digit (load_val[DIGIT_W*k +: DIGIT_W]),
            .q_digit    (q[DIGIT_W*k +: DIGIT_W]),
            .at_term    (at_term[k])
        );
    end

    // wrap_pulse marks the cycle after a whole-value rollover; it never persists.
    always_ff @(posedge clki or negedge reset) begin
        if (!reset) begin
            wrap_pulse <= 1'b0;
        end else if (load) begin
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= WRAP_EN & tc;
        end
    end

    // sat follows tc on every enabled edge, so moving away from terminal clears it; disabled edges hold.
    always_ff @(posedge clki or negedge reset) begin
        if (!reset) begin
            sat <= 1'b0;
        end else if (load) begin
            sat <= 1'b0;
        end else if (enable) begin
            sat <= ~WRAP_EN & tc;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - scoreboard bench for the wrapping and saturating counter variants
module tb_bcd_updown_counter;

    typedef struct {
        int          cyc;
        bit          sel;
        bit          kind;
        logic [7:0]  q;
        logic        tc;
        logic        wp;
        logic        sat;
        string       name;
    } exp_t;

    logic       clki = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0] q_w, q_s;
    logic       tc_w, tc_s, wp_w, wp_s, sat_w, sat_s;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t e;

    bcd_updown_counter #(.DIGITS(2), .DIGIT_MOD(10), .WRAP(1)) dut (
        .clki(clki), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
        .q(q_w), .tc(tc_w), .wrap_pulse(wp_w), .sat(sat_w)
    );

    bcd_updown_counter #(.DIGITS(2), .DIGIT_MOD(10), .WRAP(0)) dut_sat (
        .clki(clki), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
        .q(q_s), .tc(tc_s), .wrap_pulse(wp_s), .sat(sat_s)
    );

    always #5 clki = ~clki;

    always @(posedge clki) cyc <= cyc + 1;

    task automatic push(input int c, input bit sel, input bit kind, input string name,
                        input logic [7:0] eq, input logic etc, input logic ewp, input logic esat);
        exp_t x;
        x.cyc = c; x.sel = sel; x.kind = kind; x.name = name;
        x.q = eq; x.tc = etc; x.wp = ewp; x.sat = esat;
        sb.push_back(x);
    endtask

    // Drive one edge worth of inputs: tc is expected this cycle, q/wrap_pulse/sat after the edge.
    task automatic vec(input string name, input bit sel, input bit ld, input logic [7:0] lv,
                       input bit en, input bit ud, input bit etc,
                       input logic [7:0] eq, input bit ewp, input bit esat);
        @(posedge clki);
        #1;
        load = ld; load_val = lv; enable = en; up_down = ud;
        push(cyc, sel, 1'b0, {name, ".tc"}, 8'h00, etc, 1'b0, 1'b0);
        push(cyc + 1, sel, 1'b1, name, eq, 1'b0, ewp, esat);
    endtask

    // Expect the current outputs, checked at this cycle's falling edge.
    task automatic expect_now(input string name, input bit sel, input logic [7:0] eq,
                              input bit etc, input bit ewp, input bit esat);
        push(cyc, sel, 1'b0, {name, ".tc"}, 8'h00, etc, 1'b0, 1'b0);
        push(cyc, sel, 1'b1, name, eq, 1'b0, ewp, esat);
    endtask

    // Monitor: pops every expectation due at this falling edge and compares it against the selected instance.
    always @(negedge clki) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            logic [7:0] gq;
            logic       gtc, gwp, gsat;
            e    = sb.pop_front();
            gq   = e.sel ? q_s   : q_w;
            gtc  = e.sel ? tc_s  : tc_w;
            gwp  = e.sel ? wp_s  : wp_w;
            gsat = e.sel ? sat_s : sat_w;
            n_vec++;
            if (e.kind == 1'b0) begin
                if (gtc !== e.tc) begin
                    n_bad++;
                    $display("FAIL %s: got tc=%b, want tc=%b", e.name, gtc, e.tc);
                end
            end else if (e.cyc != cyc || gq !== e.q || gwp !== e.wp || gsat !== e.sat) begin
                n_bad++;
                $display("FAIL %s: got q=%h wrap_pulse=%b sat=%b (cycle %0d), want q=%h wrap_pulse=%b sat=%b (cycle %0d)",
                         e.name, gq, gwp, gsat, cyc, e.q, e.wp, e.sat, e.cyc);
            end
        end
    end

    initial begin
        // Reset held for three edges, checked while still asserted.
        repeat (3) @(posedge clki);
        #1;
        expect_now("reset_w", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_now("reset_s", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clki);
        #1;
        reset = 1'b1;

        // Down count from zero wraps to 99 with a one-cycle pulse.
        vec("down_00_99", 0, 0, 8'h00, 1, 0, 1, 8'h99, 1, 0);
        vec("down_99_98", 0, 0, 8'h00, 1, 0, 0, 8'h98, 0, 0);
        vec("down_98_97", 0, 0, 8'h00, 1, 0, 0, 8'h97, 0, 0);

        // Up cascade and whole-value rollover.
        vec("load_19",    0, 1, 8'h19, 0, 1, 0, 8'h19, 0, 0);
        vec("up_19_20",   0, 0, 8'h00, 1, 1, 0, 8'h20, 0, 0);
        vec("load_99",    0, 1, 8'h99, 0, 1, 0, 8'h99, 0, 0);
        vec("up_99_00",   0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 0);
        vec("idle_00",    0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);

        // Load beats enable; both digits clamp to 9.
        vec("load_clamp", 0, 1, 8'hAF, 1, 1, 0, 8'h99, 0, 0);
        vec("hold_99",    0, 0, 8'h00, 0, 1, 0, 8'h99, 0, 0);

        // Saturating instance: bottom end.
        vec("sat_load01", 1, 1, 8'h01, 0, 0, 0, 8'h01, 0, 0);
        vec("sat_dn_00",  1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        vec("sat_hold1",  1, 0, 8'h00, 1, 0, 1, 8'h00, 0, 1);
        vec("sat_hold2",  1, 0, 8'h00, 1, 0, 1, 8'h00, 0, 1);
        vec("sat_away",   1, 0, 8'h00, 1, 1, 0, 8'h01, 0, 0);
        vec("sat_dn_00b", 1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        vec("sat_hold3",  1, 0, 8'h00, 1, 0, 1, 8'h00, 0, 1);
        vec("sat_ld_clr", 1, 1, 8'h45, 1, 0, 0, 8'h45, 0, 0);
        // Saturating instance: top end, and sat holding while disabled.
        vec("sat_load98", 1, 1, 8'h98, 0, 1, 0, 8'h98, 0, 0);
        vec("sat_up_99",  1, 0, 8'h00, 1, 1, 0, 8'h99, 0, 0);
        vec("sat_top",    1, 0, 8'h00, 1, 1, 1, 8'h99, 0, 1);
        vec("sat_idle",   1, 0, 8'h00, 0, 1, 0, 8'h99, 0, 1);

        // Enable toggling every cycle, direction on a different phase.
        vec("gate_ld50",  0, 1, 8'h50, 0, 1, 0, 8'h50, 0, 0);
        vec("gate_c0",    0, 0, 8'h00, 1, 1, 0, 8'h51, 0, 0);
        vec("gate_c1",    0, 0, 8'h00, 0, 0, 0, 8'h51, 0, 0);
        vec("gate_c2",    0, 0, 8'h00, 1, 0, 0, 8'h50, 0, 0);
        vec("gate_c3",    0, 0, 8'h00, 0, 1, 0, 8'h50, 0, 0);
        vec("gate_c4",    0, 0, 8'h00, 1, 1, 0, 8'h51, 0, 0);
        vec("gate_c5",    0, 0, 8'h00, 0, 0, 0, 8'h51, 0, 0);
        vec("gate_c6",    0, 0, 8'h00, 1, 0, 0, 8'h50, 0, 0);
        vec("borrow_49",  0, 0, 8'h00, 1, 0, 0, 8'h49, 0, 0);
        vec("carry_50",   0, 0, 8'h00, 1, 1, 0, 8'h50, 0, 0);

        // Asynchronous reset between edges at 0x37.
        vec("ld_36",      0, 1, 8'h36, 0, 1, 0, 8'h36, 0, 0);
        vec("up_37",      0, 0, 8'h00, 1, 1, 0, 8'h37, 0, 0);
        @(posedge clki);
        #1;
        load = 1'b0; enable = 1'b0;
        @(posedge clki);
        #1;
        reset = 1'b0;
        expect_now("async_rst", 0, 8'h00, 0, 0, 0);
        @(posedge clki);
        #1;
        reset = 1'b1;
        vec("post_rst_01", 0, 0, 8'h00, 1, 1, 0, 8'h01, 0, 0);

        repeat (3) @(posedge clki);
        @(negedge clki);
        #1;
        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: got no check by cycle %0d, want check at cycle %0d", x.name, cyc, x.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised multi-digit modulo up/down counter. Successor to the single-digit 9-to-0 down counter. Adds per-digit modulus, digit cascading, direction select, parallel load, and a wrap/saturate mode. Drives seven-segment display and timer logic in the Dem_9_0 family of designs.

Parameters:
DIGITS, 2, number of cascaded digits (1..8)
DIGIT_MOD, 10, modulus of each digit; digit counts 0..DIGIT_MOD-1 (2..16)
WRAP, 1, 1 = roll over at terminal value; 0 = saturate and hold at terminal value

Ports:
clki  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
enable  input  1  count enable, sampled on clki rising edge
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load strobe
load_val  input  4*DIGITS  load value, digit k in bits [4k+3:4k]
q  output  4*DIGITS  count value, digit k in bits [4k+3:4k]
tc  output  1  terminal count (combinational)
wrap_pulse  output  1  registered one-cycle pulse on rollover
sat  output  1  registered; high while held at terminal (WRAP=0 only)

Behaviour:
- Reset (reset=0, asynchronous): q=0 in every digit, wrap_pulse=0, sat=0. The clki edge at reset release does not count. The counter releases cleanly mid-operation; no partial state is kept.
- Priority on each clki edge: load > enable > hold.
- load=1:
  - q <= load_val. Any digit >= DIGIT_MOD is clamped to DIGIT_MOD-1.
  - sat <= 0, wrap_pulse <= 0.
  - enable is ignored that cycle.
- enable=1, load=0: digit 0 steps by one (+1 if up_down=1, -1 if up_down=0).
- Digit k>0 steps only when every lower digit is at its terminal value for the current direction: DIGIT_MOD-1 when up, 0 when down.
- Digit rollover: up from DIGIT_MOD-1 goes to 0; down from 0 goes to DIGIT_MOD-1.
- tc = enable & !load & (all digits at terminal for the current direction). tc is combinational so counters can chain via enable.
- WRAP=1, tc=1 at an edge: whole value rolls over (all 9s to all 0s up; all 0s to all 9s down). wrap_pulse=1 for exactly the next cycle; otherwise wrap_pulse=0. sat stays 0.
- WRAP=0, tc=1 at an edge: q holds, sat <= 1, wrap_pulse stays 0.
  - sat clears on load, or on any enabled edge whose direction moves away from terminal.
- up_down may change on any cycle. The new direction applies at the next edge; there is no dead cycle.
- enable=0 and load=0: q, sat hold; wrap_pulse <= 0.
- Every state is reachable only with each digit < DIGIT_MOD. No illegal digit codes appear after reset or load.
- Arithmetic is per digit, 4 bits wide, modulo DIGIT_MOD. There is no binary carry between digits except through the cascade rule.

Decomposition:
- Shared package/include `counter_pkg`: DIGIT_W=4, default DIGIT_MOD, and terminal-value helper functions term_up(mod)=mod-1 and term_dn=0.
- Sub-module `bcd_digit`: one modulo digit with clki, reset, step, up_down, load, load_digit, q_digit, and at_term (combinational).
- Top: generate loop over DIGITS instantiating `bcd_digit`, an AND-chain of at_term to build each digit's step, plus the tc, wrap_pulse, and sat registers.

Test Plan:
All scenarios use defaults (DIGITS=2, DIGIT_MOD=10, WRAP=1) unless stated.
- Reset then down-count: reset low 3 cycles, release, enable=1, up_down=0 -> q steps 0x00, 0x99, 0x98 …; wrap_pulse high for one cycle after the 0x00->0x99 edge.
- Up cascade: load 0x19, then enable up -> 0x20; load 0x99, enable up -> tc=1 in the same cycle, then q=0x00 and wrap_pulse=1 for one cycle.
- Priority and clamp: load=1, enable=1, load_val=0xAF -> q=0x99 (both digits clamped); no count that edge.
- Saturate (WRAP=0): load 0x01, enable down 3 edges -> q 0x00 then holds; sat=1 from the second edge on. Switch up_down=1 -> q=0x01, sat=0.
- Enable gating and direction flip: toggle enable every cycle and up_down every 2 cycles from 0x50 -> q changes only on enabled edges, and direction follows the value sampled at that edge.
- Asynchronous reset mid-count: assert reset between clock edges at q=0x37 -> q=0x00 immediately, without waiting for clki. After release, the first enabled edge gives 0x01 (up).
